tone_seq_ctrl: RTL and testbench

//  Sequencer that plays a programmed melody on the square-wave tone path.

---
 rtl/tone_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_tone_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tone_seq_ctrl
//  Brief    : Melody sequencer. Steps through a small table of
//             (note code, duration) entries and drives the note code and tone
//             enable of the square-wave tone path, with a silent gap after
//             each note, one-shot or looped playback, and an abort input.
//  Revision : 1.0 - initial release
// ============================================================================
module tone_seq_ctrl #(
  parameter int          DEPTH      = 16,
  parameter int          BEAT_DIV   = 3_125_000,
  parameter int          GAP_CYCLES = 250_000,
  parameter logic [7:0]  MAX_NOTE   = 8'h24,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wnote,
  input  logic [3:0]    wdur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_addr,
  output logic [7:0]    note,
  output logic          tone_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_addr
);

  // Counter widths sized to their limits; a one-cycle gap still needs one bit.
  localparam int BW = $clog2(BEAT_DIV);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] C_BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] C_GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] C_ADDR_TOP  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          r_state;
  logic [11:0]     r_mem [DEPTH];
  logic [7:0]      r_lat_note;
  logic [3:0]      r_beats_left;
  logic [BW-1:0]   r_beat_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic [11:0]     w_rd;
  logic            w_audible;
  logic [AW-1:0]   w_next_addr;

  // Table read port; sampled only on the FETCH edge, so a same-edge write
  // to that entry is seen on its next fetch (read-before-write).
  assign w_rd        = r_mem[cur_addr];
  assign w_audible   = (r_lat_note != 8'h00) && (r_lat_note <= MAX_NOTE);
  assign w_next_addr = (cur_addr == C_ADDR_TOP) ? '0 : cur_addr + AW'(1);

  // Table storage: written in any state, never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= {wnote, wdur};
    end
  end

  // Playback FSM. NOTE/TONE_EN are registered from the state being left,
  // so they trail the state by one cycle except when dropping to IDLE,
  // where they are cleared on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lat_note   <= 8'h00;
      r_beats_left <= 4'd0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      note         <= 8'h00;
      tone_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_addr     <= '0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        note    <= 8'h00;
        tone_en <= 1'b0;
        if (start && !stop) begin
          cur_addr <= '0;
          busy     <= 1'b1;
          r_state  <= S_FETCH;
        end
      end else if (stop) begin
        // Abort wins over everything, including a completing gap.
        r_state <= S_IDLE;
        busy    <= 1'b0;
        note    <= 8'h00;
        tone_en <= 1'b0;
      end else begin
        case (r_state)
          S_FETCH: begin
            tone_en      <= 1'b0;
            r_lat_note   <= w_rd[11:4];
            r_beats_left <= w_rd[3:0];
            r_beat_cnt   <= '0;
            r_state      <= S_PLAY;
          end
          S_PLAY: begin
            note    <= r_lat_note;
            tone_en <= w_audible;
            if (r_beat_cnt == C_BEAT_LAST) begin
              r_beat_cnt <= '0;
              if (r_beats_left == 4'd0) begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end else begin
                r_beats_left <= r_beats_left - 4'd1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + BW'(1);
            end
          end
          S_GAP: begin
            tone_en <= 1'b0;
            if (r_gap_cnt == C_GAP_LAST) begin
              if (cur_addr != last_addr) begin
                cur_addr <= w_next_addr;
                r_state  <= S_FETCH;
              end else if (loop) begin
                cur_addr <= '0;
                r_state  <= S_FETCH;
              end else begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                note    <= 8'h00;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + GW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tone_seq_ctrl
//  Brief    : Self-checking bench for tone_seq_ctrl. Expected per-cycle
//             outputs are derived from the table contents and the timing
//             rules (fetch cycle, (dur+1) beats of tone, silent gap).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_seq_ctrl;

  localparam int         DEPTH = 16;
  localparam int         BEAT  = 4;
  localparam int         GAP   = 2;
  localparam logic [7:0] MAXN  = 8'h24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wnote = '0;
  logic [3:0] wdur = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] last_addr = '0;
  logic [7:0] note;
  logic       tone_en;
  logic       busy;
  logic       done;
  logic [3:0] cur_addr;

  tone_seq_ctrl #(
    .DEPTH(DEPTH), .BEAT_DIV(BEAT), .GAP_CYCLES(GAP), .MAX_NOTE(MAXN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wnote(wnote),
    .wdur(wdur), .start(start), .stop(stop), .loop(loop),
    .last_addr(last_addr), .note(note), .tone_en(tone_en), .busy(busy),
    .done(done), .cur_addr(cur_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] note;
    logic       tone;
    logic       busy;
    logic       done;
    logic [3:0] addr;
  } obs_t;

  int         n_assert = 0;
  int         n_fail   = 0;
  obs_t       exp_q[$];
  logic [7:0] m_note[DEPTH];
  logic [3:0] m_dur[DEPTH];
  logic [7:0] prev_note;
  logic [3:0] last_seen;

  function automatic obs_t mk(logic [7:0] n, logic t, logic b, logic d, logic [3:0] a);
    obs_t o;
    o.note = n; o.tone = t; o.busy = b; o.done = d; o.addr = a;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(note, tone_en, busy, done, cur_addr);
  endfunction

  function automatic logic audible(logic [7:0] n);
    return (n != 8'h00) && (n <= MAXN);
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed note=%h tone=%b busy=%b done=%b addr=%0d, expected note=%h tone=%b busy=%b done=%b addr=%0d",
             tag, got.note, got.tone, got.busy, got.done, got.addr,
             want.note, want.tone, want.busy, want.done, want.addr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] n, input logic [3:0] d);
    we = 1'b1; waddr = a; wnote = n; wdur = d;
    step();
    we = 1'b0;
    m_note[a] = n;
    m_dur[a]  = d;
  endtask

  // Value seen right after the edge that accepts START.
  task automatic seed();
    exp_q.delete();
    prev_note = 8'h00;
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 4'd0));
  endtask

  // One pass over entries 0..last: fetch cycle, tone beats, silent gap.
  task automatic build_pass(input logic lp, input logic [3:0] last);
    for (int i = 0; i <= int'(last); i++) begin
      logic [7:0] code;
      logic [3:0] ia;
      code = m_note[i];
      ia   = 4'(i);
      exp_q.push_back(mk(prev_note, 1'b0, 1'b1, 1'b0, ia));
      for (int c = 0; c < (int'(m_dur[i]) + 1) * BEAT; c++)
        exp_q.push_back(mk(code, audible(code), 1'b1, 1'b0, ia));
      for (int g = 0; g < GAP - 1; g++)
        exp_q.push_back(mk(code, 1'b0, 1'b1, 1'b0, ia));
      if (ia != last) begin
        exp_q.push_back(mk(code, 1'b0, 1'b1, 1'b0, ia + 4'd1));
      end else if (lp) begin
        exp_q.push_back(mk(code, 1'b0, 1'b1, 1'b0, 4'd0));
      end else begin
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, ia));
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, ia));
      end
      prev_note = code;
    end
  endtask

  // Pulse START, then compare every cycle against the expected queue.
  // Optionally rewrite entry 0 at cycle wr_at and re-pulse START at st_at.
  task automatic run_queue(input string tag, input int wr_at, input logic [7:0] wr_note, input int st_at);
    int cyc;
    obs_t e;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_seen = e.addr;
      check(tag, observe(), e);
      cyc++;
      if (cyc == wr_at) begin
        we = 1'b1; waddr = 4'd0; wnote = wr_note; wdur = m_dur[0];
      end else begin
        we = 1'b0;
      end
      start = (cyc == st_at);
      if (exp_q.size() > 0) step();
    end
    we = 1'b0;
    start = 1'b0;
  endtask

  task automatic stop_check(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check(tag, observe(), mk(8'h00, 1'b0, 1'b0, 1'b0, last_seen));
  endtask

  initial begin
    logic [3:0] rl;
    int         sel;
    logic [7:0] rn;

    // Reset values
    #2;
    check("reset", observe(), mk(8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Test 1: two-entry one-shot melody
    wr(4'd0, 8'h0A, 4'd1);
    wr(4'd1, 8'h10, 4'd0);
    loop = 1'b0; last_addr = 4'd1;
    seed(); build_pass(1'b0, 4'd1);
    run_queue("t1_oneshot", -1, 8'h00, -1);
    step();

    // Test 2: rest code and out-of-range code stay silent
    wr(4'd0, 8'h00, 4'd0);
    last_addr = 4'd0;
    seed(); build_pass(1'b0, 4'd0);
    run_queue("t2_rest", -1, 8'h00, -1);
    wr(4'd0, 8'h30, 4'd0);
    seed(); build_pass(1'b0, 4'd0);
    run_queue("t2_above_max", -1, 8'h00, -1);

    // Test 3: looped playback, two full passes, then abort
    wr(4'd0, 8'h0A, 4'd1);
    loop = 1'b1; last_addr = 4'd1;
    seed(); build_pass(1'b1, 4'd1); build_pass(1'b1, 4'd1);
    run_queue("t3_loop", -1, 8'h00, -1);
    stop_check("t3_stop");

    // Test 4: STOP mid-beat in PLAY of entry 0; START+STOP in IDLE
    loop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("t4_playing", observe(), mk(8'h0A, 1'b1, 1'b1, 1'b0, 4'd0));
    last_seen = 4'd0;
    stop_check("t4_stop");
    start = 1'b1; stop = 1'b1;
    step();
    check("t4_start_with_stop", observe(), mk(8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    start = 1'b0; stop = 1'b0;
    step();
    check("t4_idle_after", observe(), mk(8'h00, 1'b0, 1'b0, 1'b0, 4'd0));

    // Test 5: asynchronous reset mid-PLAY, then replay from beat 0
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("t5_playing", observe(), mk(8'h0A, 1'b1, 1'b1, 1'b0, 4'd0));
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", observe(), mk(8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    seed(); build_pass(1'b0, 4'd1);
    run_queue("t5_replay", -1, 8'h00, -1);

    // Test 6: rewrite the playing entry while looping; second START ignored
    loop = 1'b1;
    seed(); build_pass(1'b1, 4'd1);
    m_note[0] = 8'h20;
    build_pass(1'b1, 4'd1);
    run_queue("t6_rewrite", 3, 8'h20, 5);
    stop_check("t6_stop");

    // Randomised one-shot melodies
    loop = 1'b0;
    for (int r = 0; r < 6; r++) begin
      rl = 4'($urandom_range(0, 5));
      for (int i = 0; i <= int'(rl); i++) begin
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      rn = 8'h00;
        else if (sel == 3) rn = 8'($urandom_range(37, 255));
        else               rn = 8'($urandom_range(1, 36));
        wr(4'(i), rn, 4'($urandom_range(0, 3)));
      end
      last_addr = rl;
      seed(); build_pass(1'b0, rl);
      run_queue("rand_oneshot", -1, 8'h00, -1);
    end

    // Randomised looped melody, two passes then abort
    loop = 1'b1;
    seed(); build_pass(1'b1, last_addr); build_pass(1'b1, last_addr);
    run_queue("rand_loop", -1, 8'h00, -1);
    stop_check("rand_loop_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
